// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the memory/writeback pipeline stage.
package mem_wb_pkg;

  // Writeback source selection (11 behaves like the ALU path)
  typedef enum logic [1:0] {
    WB_PC4     = 2'b00,
    WB_ALU     = 2'b01,
    WB_LOAD    = 2'b10,
    WB_ALU_ALT = 2'b11
  } wb_sel_t;

  // RISC-V load/store funct3 size encodings
  typedef enum logic [2:0] {
    SZ_B    = 3'b000,
    SZ_H    = 3'b001,
    SZ_W    = 3'b010,
    SZ_BAD3 = 3'b011,
    SZ_BU   = 3'b100,
    SZ_HU   = 3'b101,
    SZ_BAD6 = 3'b110,
    SZ_BAD7 = 3'b111
  } mem_size_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_SIZE     = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_cause_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  localparam int          WB_DATA_W = 32;
  localparam logic [3:0]  BE_BYTE   = 4'b0001;
  localparam logic [3:0]  BE_HALF   = 4'b0011;
  localparam logic [3:0]  BE_WORD   = 4'b1111;

endpackage

// File: rtl/mem_wb_pipe_lsu_align.sv
// Combinational lane logic: store replication and byte enables, load
// extraction with sign/zero extension, and size/alignment checking.
module lsu_align
  import mem_wb_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_addr,
  input  logic        st_store,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic        illegal,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lanes and legality of the incoming operation
  always_comb begin
    be       = '0;
    wdata    = st_data;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (mem_size_t'(st_size))
      SZ_B, SZ_BU: begin
        be      = BE_BYTE << st_addr;
        wdata   = {4{st_data[7:0]}};
        illegal = st_store & st_size[2];
      end
      SZ_H, SZ_HU: begin
        be       = BE_HALF << st_addr;
        wdata    = {2{st_data[15:0]}};
        misalign = st_addr[0];
        illegal  = st_store & st_size[2];
      end
      SZ_W: begin
        be       = BE_WORD;
        misalign = (st_addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ld_byte = rdata[{ld_addr, 3'b000} +: 8];
  assign ld_half = rdata[{ld_addr[1], 4'b0000} +: 16];

  // Load lane extraction and extension for the op held in ACCESS
  always_comb begin
    ld_data = rdata;
    case (mem_size_t'(ld_size))
      SZ_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ld_data = {24'h0, ld_byte};
      SZ_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// Memory-access / writeback stage: accepts one op, performs an optional
// data-memory handshake with timeout, and emits writeback or exception.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wb_ctrl,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [2:0]        in_mem_ctrl,
  input  logic              in_reg_wr,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_pc4,
  input  logic [31:0]       in_alu,
  input  logic [31:0]       in_store_data,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_wr,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [31:0]       exc_addr
);

  state_t      state;
  logic [7:0]  cnt;
  logic        kill;
  logic [2:0]  op_size;
  wb_sel_t     op_sel;
  logic        op_reg_wr;
  logic [4:0]  op_rd;
  logic [31:0] op_pc4;
  logic [31:0] op_alu;
  logic        wb_valid_r;
  logic        exc_valid_r;

  logic        is_mem;
  logic        is_store;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld_data;
  logic        misalign;
  logic        illegal;
  logic [31:0] direct_data;
  logic [31:0] resp_data;
  logic        drop;

  assign is_mem   = in_mem_rd | in_mem_wr;
  assign is_store = in_mem_wr;
  assign in_ready = (state == S_IDLE);
  // A flush seen while any part of the held op is in flight discards its result
  assign drop     = kill | flush;

  // Flush arriving during RESP must cancel the pulse already on the outputs
  assign wb_valid  = wb_valid_r  & ~(flush & (state == S_RESP));
  assign exc_valid = exc_valid_r & ~(flush & (state == S_RESP));

  lsu_align u_lsu (
    .st_size  (in_mem_ctrl),
    .st_addr  (in_alu[1:0]),
    .st_store (is_store),
    .st_data  (in_store_data),
    .be       (be),
    .wdata    (wdata),
    .misalign (misalign),
    .illegal  (illegal),
    .ld_size  (op_size),
    .ld_addr  (op_alu[1:0]),
    .rdata    (dmem_rdata),
    .ld_data  (ld_data)
  );

  // Writeback value for ops that complete directly from IDLE
  always_comb begin
    direct_data = in_alu;
    case (wb_sel_t'(in_wb_ctrl))
      WB_PC4:  direct_data = in_pc4;
      WB_LOAD: direct_data = '0;
      default: direct_data = in_alu;
    endcase
  end

  // Writeback value for the op held through a memory access
  always_comb begin
    resp_data = op_alu;
    case (op_sel)
      WB_PC4:  resp_data = op_pc4;
      WB_LOAD: resp_data = ld_data;
      default: resp_data = op_alu;
    endcase
  end

  // Control FSM, timeout counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      kill        <= 1'b0;
      op_size     <= '0;
      op_sel      <= WB_PC4;
      op_reg_wr   <= 1'b0;
      op_rd       <= '0;
      op_pc4      <= '0;
      op_alu      <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_valid_r  <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_reg_wr   <= 1'b0;
      exc_valid_r <= 1'b0;
      exc_cause   <= EXC_NONE;
      exc_addr    <= '0;
    end else begin
      wb_valid_r  <= 1'b0;
      exc_valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            if (!is_mem) begin
              wb_valid_r <= 1'b1;
              wb_data    <= direct_data;
              wb_rd      <= in_rd;
              wb_reg_wr  <= in_reg_wr && (in_rd != 5'd0);
            end else if (illegal || misalign) begin
              wb_valid_r  <= 1'b1;
              exc_valid_r <= 1'b1;
              exc_cause   <= illegal ? EXC_SIZE : EXC_MISALIGN;
              exc_addr    <= in_alu;
              wb_data     <= in_alu;
              wb_rd       <= in_rd;
              wb_reg_wr   <= 1'b0;
            end else begin
              state      <= S_ACCESS;
              cnt        <= '0;
              kill       <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= in_alu[ADDR_W-1:2];
              dmem_be    <= be;
              dmem_wdata <= wdata;
              op_size    <= in_mem_ctrl;
              op_sel     <= wb_sel_t'(in_wb_ctrl);
              op_reg_wr  <= in_reg_wr && !is_store && (in_rd != 5'd0);
              op_rd      <= in_rd;
              op_pc4     <= in_pc4;
              op_alu     <= in_alu;
            end
          end
        end
        S_ACCESS: begin
          if (flush) kill <= 1'b1;
          if (dmem_ack) begin
            state    <= S_RESP;
            dmem_req <= 1'b0;
            cnt      <= '0;
            if (!drop) begin
              wb_valid_r <= 1'b1;
              wb_data    <= resp_data;
              wb_rd      <= op_rd;
              wb_reg_wr  <= op_reg_wr;
            end
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state    <= S_RESP;
            dmem_req <= 1'b0;
            cnt      <= '0;
            if (!drop) begin
              wb_valid_r  <= 1'b1;
              exc_valid_r <= 1'b1;
              exc_cause   <= EXC_TIMEOUT;
              exc_addr    <= op_alu;
              wb_rd       <= op_rd;
              wb_reg_wr   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          kill  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: behavioural model plus per-cycle compare.
module tb_mem_wb_pipe;

  localparam int AW = 12;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_wb_ctrl = '0;
  logic          in_mem_rd = 1'b0;
  logic          in_mem_wr = 1'b0;
  logic [2:0]    in_mem_ctrl = '0;
  logic          in_reg_wr = 1'b0;
  logic [4:0]    in_rd = '0;
  logic [31:0]   in_pc4 = '0;
  logic [31:0]   in_alu = '0;
  logic [31:0]   in_store_data = '0;
  logic          flush = 1'b0;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-3:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack = 1'b0;
  logic [31:0]   dmem_rdata = '0;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic [4:0]    wb_rd;
  logic          wb_reg_wr;
  logic          exc_valid;
  logic [1:0]    exc_cause;
  logic [31:0]   exc_addr;

  mem_wb_pipe #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_ctrl(in_wb_ctrl), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_mem_ctrl(in_mem_ctrl), .in_reg_wr(in_reg_wr), .in_rd(in_rd),
    .in_pc4(in_pc4), .in_alu(in_alu), .in_store_data(in_store_data),
    .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic [1:0]  wbc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] sd;
  } op_t;

  typedef struct packed {
    logic        illegal;
    logic        misalign;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
  } res_t;

  typedef struct {
    int          cyc;
    bit          exc;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    logic        reg_wr;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b1;
  int   req_lo = -10;
  int   req_hi = -20;
  logic [31:0] x_addr = '0;
  logic [3:0]  x_be = '0;
  logic [31:0] x_wd = '0;
  logic        x_we = 1'b0;
  ev_t  evq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: sizes in bytes, offsets, arithmetic replication/extension
  function automatic res_t model(input op_t o, input logic [31:0] rdata);
    res_t r;
    int nb;
    int ofs;
    logic [31:0] v;
    r = '0;
    nb  = (o.f3[1:0] == 2'd0) ? 1 : (o.f3[1:0] == 2'd1) ? 2 : 4;
    ofs = int'(o.alu[1:0]);
    r.illegal  = (o.f3 == 3'd3) || (o.f3 >= 3'd6) || (o.mem_wr && o.f3 >= 3'd4);
    r.misalign = !r.illegal && ((ofs % nb) != 0);
    r.be       = 4'(((1 << nb) - 1) << ofs);
    r.wdata    = (nb == 1) ? o.sd[7:0] * 32'h01010101 :
                 (nb == 2) ? o.sd[15:0] * 32'h00010001 : o.sd;
    v = rdata >> (8 * ofs);
    if (nb == 1) begin
      v = v & 32'hFF;
      if (!o.f3[2] && v[7]) v = v | 32'hFFFFFF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (!o.f3[2] && v[15]) v = v | 32'hFFFF0000;
    end
    r.ld = v;
    return r;
  endfunction

  function automatic op_t mk(input logic rd_, input logic wr_, input logic [2:0] f3,
                             input logic [1:0] wbc, input logic rw, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] sd);
    op_t o;
    o.mem_rd = rd_; o.mem_wr = wr_; o.f3 = f3; o.wbc = wbc; o.reg_wr = rw;
    o.rd = rd; o.alu = alu; o.sd = sd; o.pc4 = 32'h0040_0004 ^ (alu << 4);
    return o;
  endfunction

  // Drive one op and register what the model says must follow.
  // ack_n: ACCESS cycle carrying ack (0 = never); flush_at: ACCESS cycle
  // with flush (n+1 = RESP cycle, 0 = none); flush_xfer: flush on transfer.
  task automatic run_op(input op_t o, input logic [31:0] rdata, input int ack_n,
                        input int flush_at, input bit flush_xfer);
    res_t r;
    ev_t  e;
    int   t;
    int   n;
    bit   mem;
    r   = model(o, rdata);
    mem = o.mem_rd || o.mem_wr;
    in_valid = 1'b1; in_wb_ctrl = o.wbc; in_mem_rd = o.mem_rd; in_mem_wr = o.mem_wr;
    in_mem_ctrl = o.f3; in_reg_wr = o.reg_wr; in_rd = o.rd; in_pc4 = o.pc4;
    in_alu = o.alu; in_store_data = o.sd; flush = flush_xfer;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    t = cyc;
    e.cyc = t; e.exc = 1'b0; e.cause = 2'b00; e.addr = o.alu; e.rd = o.rd;
    e.chk_data = 1'b1;
    e.data = (o.wbc == 2'b00) ? o.pc4 : (o.wbc == 2'b10) ? r.ld : o.alu;
    e.reg_wr = o.reg_wr && !o.mem_wr && (o.rd != 5'd0);
    if (flush_xfer) begin
      // accepted and discarded: nothing expected
    end else if (!mem) begin
      if (o.wbc == 2'b10) e.chk_data = 1'b0;
      evq.push_back(e);
    end else if (r.illegal || r.misalign) begin
      e.exc = 1'b1; e.cause = r.illegal ? 2'b10 : 2'b01; e.reg_wr = 1'b0; e.chk_data = 1'b0;
      evq.push_back(e);
    end else begin
      n = (ack_n == 0) ? TO : ack_n;
      x_addr = {22'h0, o.alu[AW-1:2]}; x_be = r.be; x_wd = r.wdata; x_we = o.mem_wr;
      req_lo = t; req_hi = t + n - 1;
      if (ack_n == 0) begin
        e.exc = 1'b1; e.cause = 2'b11; e.reg_wr = 1'b0; e.chk_data = 1'b0;
      end
      e.cyc = t + n;
      if (flush_at == 0) evq.push_back(e);
      for (int i = 1; i <= n; i++) begin
        dmem_ack   = (ack_n != 0) && (i == n);
        dmem_rdata = dmem_ack ? rdata : 32'hA5A5_5A5A;
        flush      = (i == flush_at);
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0; dmem_rdata = 32'h0; flush = (flush_at == n + 1);
      @(posedge clk); #1;
      flush = 1'b0;
    end
  endtask

  // Per-cycle compare of DUT outputs against the model's expectations
  always @(negedge clk) begin : cmp
    bit  er;
    ev_t e;
    if (chk_en && rst_n) begin
      er = (cyc >= req_lo) && (cyc <= req_hi);
      chk("dmem_req", dmem_req, er);
      chk("in_ready", in_ready, !((cyc >= req_lo) && (cyc <= req_hi + 1)));
      if (er) begin
        chk("dmem_addr", {22'h0, dmem_addr}, x_addr);
        chk("dmem_we", dmem_we, x_we);
        if (x_we) begin
          chk("dmem_be", dmem_be, x_be);
          chk("dmem_wdata", dmem_wdata, x_wd);
        end
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        chk("wb_event_missed", 32'(e.cyc), 32'(cyc));
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        chk("wb_valid", wb_valid, 1);
        chk("exc_valid", exc_valid, e.exc);
        chk("wb_reg_wr", wb_reg_wr, e.reg_wr);
        if (e.exc) begin
          chk("exc_cause", exc_cause, e.cause);
          chk("exc_addr", exc_addr, e.addr);
        end else begin
          chk("wb_rd", wb_rd, e.rd);
        end
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end else begin
        chk("wb_valid_idle", wb_valid, 0);
        chk("exc_valid_idle", exc_valid, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    // Pin the model to hand-computed values
    r = model(mk(1, 0, 3'b000, 2'b10, 1, 3, 32'h2, 0), 32'h0080_0000);
    chk("pin_lb", r.ld, 32'hFFFF_FF80);
    r = model(mk(1, 0, 3'b100, 2'b10, 1, 3, 32'h2, 0), 32'h0080_0000);
    chk("pin_lbu", r.ld, 32'h0000_0080);
    r = model(mk(1, 0, 3'b001, 2'b10, 1, 3, 32'h2, 0), 32'h8001_0000);
    chk("pin_lh", r.ld, 32'hFFFF_8001);
    r = model(mk(0, 1, 3'b000, 2'b01, 0, 0, 32'h103, 32'hAB), 32'h0);
    chk("pin_sb_be", r.be, 32'h8);
    chk("pin_sb_wdata", r.wdata, 32'hABAB_ABAB);
    r = model(mk(1, 0, 3'b010, 2'b10, 1, 3, 32'h6, 0), 32'h0);
    chk("pin_lw_misalign", r.misalign, 1);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_dmem_addr", {22'h0, dmem_addr}, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_reg_wr", wb_reg_wr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_exc_cause", exc_cause, 0);
    chk("rst_exc_addr", exc_addr, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Non-memory ops, back to back
    run_op(mk(0, 0, 3'b000, 2'b01, 1, 5, 32'h1234, 0), 0, 0, 0, 0);
    run_op(mk(0, 0, 3'b000, 2'b00, 1, 7, 32'h55, 0), 0, 0, 0, 0);
    run_op(mk(0, 0, 3'b000, 2'b11, 1, 0, 32'h77, 0), 0, 0, 0, 0);
    run_op(mk(0, 0, 3'b000, 2'b01, 0, 9, 32'h88, 0), 0, 0, 0, 0);
    // Stores
    run_op(mk(0, 1, 3'b000, 2'b01, 0, 0, 32'h103, 32'hAB), 0, 3, 0, 0);
    run_op(mk(0, 1, 3'b001, 2'b01, 0, 0, 32'h102, 32'h1234_BEEF), 0, 1, 0, 0);
    run_op(mk(0, 1, 3'b010, 2'b00, 1, 6, 32'h100, 32'hCAFE_F00D), 0, 2, 0, 0);
    run_op(mk(1, 1, 3'b000, 2'b01, 1, 4, 32'h201, 32'h5A), 0, 1, 0, 0);
    // Loads
    run_op(mk(1, 0, 3'b000, 2'b10, 1, 3, 32'h002, 0), 32'h0080_0000, 1, 0, 0);
    run_op(mk(1, 0, 3'b100, 2'b10, 1, 3, 32'h002, 0), 32'h0080_0000, 1, 0, 0);
    run_op(mk(1, 0, 3'b001, 2'b10, 1, 10, 32'h002, 0), 32'h8001_0000, 2, 0, 0);
    run_op(mk(1, 0, 3'b101, 2'b10, 1, 11, 32'h002, 0), 32'h8001_0000, 1, 0, 0);
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 12, 32'h004, 0), 32'hDEAD_BEEF, 2, 0, 0);
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 0, 32'h008, 0), 32'h1111_2222, 1, 0, 0);
    // Exceptions from IDLE
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 3, 32'h006, 0), 0, 1, 0, 0);
    run_op(mk(1, 0, 3'b001, 2'b10, 1, 3, 32'h001, 0), 0, 1, 0, 0);
    run_op(mk(1, 0, 3'b011, 2'b10, 1, 3, 32'h020, 0), 0, 1, 0, 0);
    run_op(mk(0, 1, 3'b100, 2'b01, 0, 0, 32'h030, 32'h1), 0, 1, 0, 0);
    run_op(mk(0, 1, 3'b110, 2'b01, 0, 0, 32'h034, 32'h1), 0, 1, 0, 0);
    // Timeout, and ack on the last allowed cycle
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 8, 32'h040, 0), 0, 0, 0, 0);
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 8, 32'h044, 0), 32'h1234_5678, TO, 0, 0);
    // Flush cases
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 9, 32'h048, 0), 32'h0BAD_0BAD, 4, 2, 0);
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 9, 32'h04C, 0), 32'h0BAD_0BAD, 2, 3, 0);
    run_op(mk(0, 0, 3'b000, 2'b01, 1, 5, 32'h99, 0), 0, 0, 0, 1);
    run_op(mk(1, 0, 3'b010, 2'b10, 1, 5, 32'h050, 0), 0, 1, 0, 1);
    run_op(mk(0, 0, 3'b000, 2'b01, 1, 13, 32'hABCD, 0), 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of an access
    chk_en = 1'b0;
    in_valid = 1'b1; in_mem_rd = 1'b1; in_mem_wr = 1'b0; in_mem_ctrl = 3'b010;
    in_alu = 32'h10; in_rd = 5'd4; in_reg_wr = 1'b1; in_wb_ctrl = 2'b10;
    @(posedge clk); #1;
    in_valid = 1'b0; in_mem_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_req_before_rst", dmem_req, 1);
    chk("mid_ready_before_rst", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_addr", {22'h0, dmem_addr}, 0);
    chk("mid_rst_be", dmem_be, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_mid_rst_ready", in_ready, 1);
    chk("post_mid_rst_req", dmem_req, 0);
    req_lo = -10; req_hi = -20;
    chk_en = 1'b1;
    run_op(mk(0, 0, 3'b000, 2'b01, 1, 14, 32'h4321, 0), 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("events_drained", 32'(evq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width into data memory; legal range 4..30.
REQ-002 Parameter TIMEOUT, default 15, max cycles to wait for dmem_ack before bus error; legal range 1..255.
REQ-003 Ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: in_valid in 1 upstream op valid; in_ready out 1 stage can accept.
REQ-006 Ports: in_wb_ctrl in 2 (00 pc+4, 01 alu, 10 load, 11 treated as alu); in_mem_rd in 1; in_mem_wr in 1; in_mem_ctrl in 3 (RISC-V funct3); in_reg_wr in 1; in_rd in 5.
REQ-007 Ports: in_pc4 in 32; in_alu in 32 (result or byte address); in_store_data in 32.
REQ-008 Ports: flush in 1, kill current and incoming op.
REQ-009 Ports: dmem_req out 1; dmem_we out 1; dmem_addr out ADDR_W-2 word address; dmem_be out 4; dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-010 Ports: wb_valid out 1; wb_data out 32; wb_rd out 5; wb_reg_wr out 1; exc_valid out 1; exc_cause out 2 (01 misalign, 10 illegal size, 11 bus timeout); exc_addr out 32.

Function
REQ-011 Transfer occurs when in_valid and in_ready are both high on a rising edge; in_ready SHALL be high only in state IDLE.
REQ-012 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted legal aligned memory op; ACCESS->RESP on dmem_ack or timeout; RESP->IDLE unconditionally.
REQ-013 Non-memory op (mem_rd=mem_wr=0): wb_valid asserts exactly one cycle after transfer, FSM stays IDLE, back-to-back ops sustain one per cycle.
REQ-014 Memory op: dmem_req high every cycle in ACCESS, starting the cycle after transfer; dmem_we, dmem_addr, dmem_be, dmem_wdata held stable while dmem_req high.
REQ-015 Request completes on the cycle dmem_req and dmem_ack both high; dmem_req SHALL drop next cycle; wb_valid asserts in RESP (one cycle after ack).
REQ-016 mem_rd and mem_wr both high: treated as store.
REQ-017 Sizes: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 raise illegal-size exception (stores: 100/101 also illegal).
REQ-018 Misalign: half with addr[0]=1, word with addr[1:0]!=0 raise misalign exception.
REQ-019 Exceptions: no memory request issued, exc_valid and wb_valid pulse one cycle after transfer, wb_reg_wr=0, exc_addr=in_alu; timeout exception reported in RESP with wb_reg_wr=0.
REQ-020 Store lanes: byte data replicated to all lanes, be=0001<<addr[1:0]; half replicated, be=0011<<addr[1:0]; word be=1111.
REQ-021 Load: selected lane extracted by addr[1:0], sign- or zero-extended per funct3 to 32 bits, captured on the ack cycle.
REQ-022 wb_data selects pc4/alu/load data per wb_ctrl; stores and reg_wr=0 ops produce wb_reg_wr=0 regardless of wb_ctrl.
REQ-023 Writes to rd=0 SHALL produce wb_reg_wr=0.
REQ-024 Timeout counter starts at 0 on entering ACCESS, increments each cycle without ack; reaching TIMEOUT ends ACCESS with cause 11, dmem_req dropped.
REQ-025 Ack and counter reaching TIMEOUT in same cycle: ack wins, no exception.
REQ-026 flush in IDLE with in_valid high: op accepted and discarded, no dmem_req, no wb_valid, no exception.
REQ-027 flush during ACCESS: request still held until ack/timeout (no abandoned handshake), result and any exception suppressed; flush during RESP suppresses wb_valid and exc_valid.
REQ-028 wb_valid and exc_valid are single-cycle pulses; wb_data/wb_rd hold last value otherwise.

Reset
REQ-029 rst_n low SHALL immediately force FSM to IDLE, counter 0, kill flag 0, and outputs dmem_req, dmem_we, wb_valid, wb_reg_wr, exc_valid to 0, dmem_be 0, all data/address outputs 0, exc_cause 00.
REQ-030 Reset during ACCESS abandons request; in_ready high first rising edge after rst_n deasserts.

Structure
REQ-031 Package mem_wb_pkg holds wb_sel_t, mem_size_t (funct3 encodings), exc_cause_t, state_t and WB/EXC constants.
REQ-032 One combinational sub-module lsu_align: store lane shift and byte enables, load extract and extend, misalign/illegal detection.
REQ-033 FSM, timeout counter, output registers reside in mem_wb_pipe.

Verification
REQ-034 ALU op alu=0x1234, wb_ctrl=01, rd=5 -> next cycle wb_valid=1, wb_data=0x00001234, wb_rd=5, wb_reg_wr=1, no dmem_req.
REQ-035 SB addr=0x103, data=0xAB, ack after 3 cycles -> dmem_addr=0x40, be=1000, wdata=0xABABABAB, wb_reg_wr=0 in RESP.
REQ-036 LB addr=0x002, rdata=0x00800000, ack 1 cycle -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 LW addr=0x006 -> no dmem_req, exc_valid=1, exc_cause=01, exc_addr=0x6, wb_reg_wr=0.
REQ-038 LW, dmem_ack never asserted, TIMEOUT=15 -> dmem_req high 15 cycles, then exc_cause=11, in_ready returns.
REQ-039 LW with flush asserted second ACCESS cycle, ack cycle 4 -> dmem_req held until ack, no wb_valid, no exc_valid.
